// File: rtl/core_bus_arbiter.sv
// Merges the core's instruction-fetch and data ports onto one single-beat memory port.
// One request is in flight at a time; the winner is latched and replayed to memory until it completes.
module core_bus_arbiter #(
  parameter bit DPRIO = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ireq_valid,
  input  logic [63:0] ireq_addr,
  output logic        iresp_addr_ok,
  output logic        iresp_data_ok,
  output logic [31:0] iresp_data,
  input  logic        dreq_valid,
  input  logic [63:0] dreq_addr,
  input  logic [2:0]  dreq_size,
  input  logic [7:0]  dreq_strobe,
  input  logic [63:0] dreq_data,
  output logic        dresp_addr_ok,
  output logic        dresp_data_ok,
  output logic [63:0] dresp_data,
  output logic        mreq_valid,
  output logic        mreq_write,
  output logic [63:0] mreq_addr,
  output logic [2:0]  mreq_size,
  output logic [7:0]  mreq_strobe,
  output logic [63:0] mreq_wdata,
  input  logic        mresp_ready,
  input  logic [63:0] mresp_data
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] IBUSY = 2'd1;
  localparam logic [1:0] DBUSY = 2'd2;

  logic [1:0] state;
  logic       last_grant;
  logic       tie_to_d;
  logic       grant_d;
  logic       grant_i;
  logic       i_done;
  logic       d_done;

  // With a one-bit history both priority settings collapse to strict alternation on ties:
  // the port that was not served last wins.
  always_comb begin
    tie_to_d = DPRIO ? (last_grant == 1'b0) : !(last_grant == 1'b1);
    grant_d  = dreq_valid && (!ireq_valid || tie_to_d);
    grant_i  = ireq_valid && !grant_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      last_grant  <= 1'b0;
      mreq_valid  <= 1'b0;
      mreq_write  <= 1'b0;
      mreq_addr   <= 64'h0;
      mreq_size   <= 3'd0;
      mreq_strobe <= 8'h00;
      mreq_wdata  <= 64'h0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_d) begin
            state       <= DBUSY;
            last_grant  <= 1'b1;
            mreq_valid  <= 1'b1;
            mreq_write  <= |dreq_strobe;
            mreq_addr   <= dreq_addr;
            mreq_size   <= dreq_size;
            mreq_strobe <= dreq_strobe;
            mreq_wdata  <= dreq_data;
          end else if (grant_i) begin
            state       <= IBUSY;
            last_grant  <= 1'b0;
            mreq_valid  <= 1'b1;
            mreq_write  <= 1'b0;
            mreq_addr   <= ireq_addr;
            mreq_size   <= 3'd2;
            mreq_strobe <= 8'h00;
            mreq_wdata  <= 64'h0;
          end
        end
        IBUSY, DBUSY: begin
          if (mresp_ready) begin
            state      <= IDLE;
            mreq_valid <= 1'b0;
          end
        end
        default: begin
          state      <= IDLE;
          mreq_valid <= 1'b0;
        end
      endcase
    end
  end

  // A port that withdrew its request before completion gets no pulse and sees zero data.
  always_comb begin
    i_done        = (state == IBUSY) && mresp_ready && ireq_valid;
    d_done        = (state == DBUSY) && mresp_ready && dreq_valid;
    iresp_addr_ok = i_done;
    iresp_data_ok = i_done;
    iresp_data    = 32'h0;
    if (i_done) begin
      iresp_data = mreq_addr[2] ? mresp_data[63:32] : mresp_data[31:0];
    end
    dresp_addr_ok = d_done;
    dresp_data_ok = d_done;
    dresp_data    = d_done ? mresp_data : 64'h0;
  end

endmodule

// File: tb/tb_core_bus_arbiter.sv
// Directed table-driven bench for core_bus_arbiter: each table row is one clock cycle
// of inputs plus the outputs expected during that cycle.
module tb_core_bus_arbiter;

  logic        clk;
  logic        reset;
  logic        ireq_valid;
  logic [63:0] ireq_addr;
  logic        iresp_addr_ok;
  logic        iresp_data_ok;
  logic [31:0] iresp_data;
  logic        dreq_valid;
  logic [63:0] dreq_addr;
  logic [2:0]  dreq_size;
  logic [7:0]  dreq_strobe;
  logic [63:0] dreq_data;
  logic        dresp_addr_ok;
  logic        dresp_data_ok;
  logic [63:0] dresp_data;
  logic        mreq_valid;
  logic        mreq_write;
  logic [63:0] mreq_addr;
  logic [2:0]  mreq_size;
  logic [7:0]  mreq_strobe;
  logic [63:0] mreq_wdata;
  logic        mresp_ready;
  logic [63:0] mresp_data;

  int n_cmp;
  int n_fail;

  core_bus_arbiter #(.DPRIO(1'b1)) dut (
    .clk(clk), .reset(reset),
    .ireq_valid(ireq_valid), .ireq_addr(ireq_addr),
    .iresp_addr_ok(iresp_addr_ok), .iresp_data_ok(iresp_data_ok), .iresp_data(iresp_data),
    .dreq_valid(dreq_valid), .dreq_addr(dreq_addr), .dreq_size(dreq_size),
    .dreq_strobe(dreq_strobe), .dreq_data(dreq_data),
    .dresp_addr_ok(dresp_addr_ok), .dresp_data_ok(dresp_data_ok), .dresp_data(dresp_data),
    .mreq_valid(mreq_valid), .mreq_write(mreq_write), .mreq_addr(mreq_addr),
    .mreq_size(mreq_size), .mreq_strobe(mreq_strobe), .mreq_wdata(mreq_wdata),
    .mresp_ready(mresp_ready), .mresp_data(mresp_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ctl = {reset, ireq_valid, dreq_valid, mresp_ready}
  // eflg = {iaddr_ok, idata_ok, daddr_ok, ddata_ok, mreq_valid, check_m_fields, mreq_write}
  typedef struct {
    string       name;
    logic [3:0]  ctl;
    logic [63:0] ia;
    logic [63:0] da;
    logic [2:0]  dsz;
    logic [7:0]  dst;
    logic [63:0] dwd;
    logic [63:0] md;
    logic [6:0]  eflg;
    logic [31:0] eid;
    logic [63:0] edd;
    logic [63:0] ema;
    logic [2:0]  emsz;
    logic [7:0]  emst;
    logic [63:0] emwd;
  } vec_t;

  localparam logic [63:0] Z   = 64'h0;
  localparam logic [31:0] Z32 = 32'h0;
  localparam logic [2:0]  Z3  = 3'd0;
  localparam logic [7:0]  Z8  = 8'h00;

  vec_t vecs[$];

  task automatic row(input string name, input logic [3:0] ctl, input logic [63:0] ia,
                     input logic [63:0] da, input logic [2:0] dsz, input logic [7:0] dst,
                     input logic [63:0] dwd, input logic [63:0] md, input logic [6:0] eflg,
                     input logic [31:0] eid, input logic [63:0] edd, input logic [63:0] ema,
                     input logic [2:0] emsz, input logic [7:0] emst, input logic [63:0] emwd);
    vec_t v;
    v.name = name; v.ctl = ctl; v.ia = ia; v.da = da; v.dsz = dsz; v.dst = dst;
    v.dwd = dwd; v.md = md; v.eflg = eflg; v.eid = eid; v.edd = edd; v.ema = ema;
    v.emsz = emsz; v.emst = emst; v.emwd = emwd;
    vecs.push_back(v);
  endtask

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    reset       = v.ctl[3];
    ireq_valid  = v.ctl[2];
    dreq_valid  = v.ctl[1];
    mresp_ready = v.ctl[0];
    ireq_addr   = v.ia;
    dreq_addr   = v.da;
    dreq_size   = v.dsz;
    dreq_strobe = v.dst;
    dreq_data   = v.dwd;
    mresp_data  = v.md;
  endtask

  task automatic checkOutput(input vec_t v);
    cmp({v.name, ".ok"}, {60'h0, iresp_addr_ok, iresp_data_ok, dresp_addr_ok, dresp_data_ok},
        {60'h0, v.eflg[6:3]});
    cmp({v.name, ".idata"}, {32'h0, iresp_data}, {32'h0, v.eid});
    cmp({v.name, ".ddata"}, dresp_data, v.edd);
    cmp({v.name, ".mvalid"}, {63'h0, mreq_valid}, {63'h0, v.eflg[2]});
    if (v.eflg[1]) begin
      cmp({v.name, ".mwrite"}, {63'h0, mreq_write}, {63'h0, v.eflg[0]});
      cmp({v.name, ".maddr"}, mreq_addr, v.ema);
      cmp({v.name, ".msize"}, {61'h0, mreq_size}, {61'h0, v.emsz});
      cmp({v.name, ".mstrobe"}, {56'h0, mreq_strobe}, {56'h0, v.emst});
      cmp({v.name, ".mwdata"}, mreq_wdata, v.emwd);
    end
  endtask

  initial begin
    int waited;
    n_cmp  = 0;
    n_fail = 0;

    row("rst_idle",  4'b0000, Z, Z, Z3, Z8, Z, Z, 7'b0000_010, Z32, Z, Z, Z3, Z8, Z);
    // fetch only, three-cycle memory, upper word selected
    row("f_grant",   4'b0100, 64'h8000_0004, Z, Z3, Z8, Z, Z, 7'b0000_000, Z32, Z, Z, Z3, Z8, Z);
    row("f_wait1",   4'b0100, 64'h8000_0004, Z, Z3, Z8, Z, Z, 7'b0000_110, Z32, Z, 64'h8000_0004, 3'd2, Z8, Z);
    row("f_wait2",   4'b0100, 64'h8000_0004, Z, Z3, Z8, Z, Z, 7'b0000_110, Z32, Z, 64'h8000_0004, 3'd2, Z8, Z);
    row("f_done",    4'b0101, 64'h8000_0004, Z, Z3, Z8, Z, 64'h1111_2222_3333_4444, 7'b1100_110, 32'h1111_2222, Z, 64'h8000_0004, 3'd2, Z8, Z);
    row("f_idle",    4'b0000, Z, Z, Z3, Z8, Z, Z, 7'b0000_000, Z32, Z, Z, Z3, Z8, Z);
    // simultaneous requests alternate d, i, d
    row("s_both",    4'b0110, 64'h8000_0000, 64'h8000_1000, 3'd3, Z8, Z, Z, 7'b0000_000, Z32, Z, Z, Z3, Z8, Z);
    row("s_d_done",  4'b0111, 64'h8000_0000, 64'h8000_1000, 3'd3, Z8, Z, 64'hDEAD_BEEF_0123_4567, 7'b0011_110, Z32, 64'hDEAD_BEEF_0123_4567, 64'h8000_1000, 3'd3, Z8, Z);
    row("s_gap",     4'b0110, 64'h8000_0000, 64'h8000_1000, 3'd3, Z8, Z, Z, 7'b0000_000, Z32, Z, Z, Z3, Z8, Z);
    row("s_i_done",  4'b0111, 64'h8000_0000, 64'h8000_1000, 3'd3, Z8, Z, 64'hAAAA_BBBB_CCCC_DDDD, 7'b1100_110, 32'hCCCC_DDDD, Z, 64'h8000_0000, 3'd2, Z8, Z);
    row("s_gap2",    4'b0110, 64'h8000_0000, 64'h8000_1000, 3'd3, Z8, Z, Z, 7'b0000_000, Z32, Z, Z, Z3, Z8, Z);
    row("s_d_again", 4'b0111, 64'h8000_0000, 64'h8000_1000, 3'd3, Z8, Z, 64'h0102_0304_0506_0708, 7'b0011_110, Z32, 64'h0102_0304_0506_0708, 64'h8000_1000, 3'd3, Z8, Z);
    row("s_idle",    4'b0000, Z, Z, Z3, Z8, Z, Z, 7'b0000_000, Z32, Z, Z, Z3, Z8, Z);
    // byte write with a five-cycle stall; dbus inputs wander while busy
    row("w_grant",   4'b0010, Z, 64'h100, 3'd0, 8'h04, 64'h00AB_0000, Z, 7'b0000_000, Z32, Z, Z, Z3, Z8, Z);
    row("w_stall1",  4'b0010, Z, 64'h100, 3'd0, 8'h04, 64'h00AB_0000, Z, 7'b0000_111, Z32, Z, 64'h100, 3'd0, 8'h04, 64'h00AB_0000);
    row("w_stall2",  4'b0010, Z, 64'h100, 3'd0, 8'h04, 64'h00AB_0000, Z, 7'b0000_111, Z32, Z, 64'h100, 3'd0, 8'h04, 64'h00AB_0000);
    row("w_stall3",  4'b0010, Z, 64'h200, 3'd3, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF, Z, 7'b0000_111, Z32, Z, 64'h100, 3'd0, 8'h04, 64'h00AB_0000);
    row("w_stall4",  4'b0010, Z, 64'h200, 3'd3, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF, Z, 7'b0000_111, Z32, Z, 64'h100, 3'd0, 8'h04, 64'h00AB_0000);
    row("w_stall5",  4'b0010, Z, 64'h200, 3'd3, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF, Z, 7'b0000_111, Z32, Z, 64'h100, 3'd0, 8'h04, 64'h00AB_0000);
    row("w_done",    4'b0011, Z, 64'h100, 3'd0, 8'h04, 64'h00AB_0000, 64'h5555_5555_5555_5555, 7'b0011_111, Z32, 64'h5555_5555_5555_5555, 64'h100, 3'd0, 8'h04, 64'h00AB_0000);
    row("w_idle",    4'b0000, Z, Z, Z3, Z8, Z, Z, 7'b0000_000, Z32, Z, Z, Z3, Z8, Z);
    // fetch withdrawn before completion, then a normal data read
    row("wd_grant",  4'b0100, 64'h8000_0008, Z, Z3, Z8, Z, Z, 7'b0000_000, Z32, Z, Z, Z3, Z8, Z);
    row("wd_drop",   4'b0000, Z, Z, Z3, Z8, Z, Z, 7'b0000_110, Z32, Z, 64'h8000_0008, 3'd2, Z8, Z);
    row("wd_done",   4'b0001, Z, Z, Z3, Z8, Z, 64'h9999_8888_7777_6666, 7'b0000_110, Z32, Z, 64'h8000_0008, 3'd2, Z8, Z);
    row("wd_next",   4'b0010, Z, 64'h300, 3'd3, Z8, Z, Z, 7'b0000_000, Z32, Z, Z, Z3, Z8, Z);
    row("wd_d_done", 4'b0011, Z, 64'h300, 3'd3, Z8, Z, 64'h1234, 7'b0011_110, Z32, 64'h1234, 64'h300, 3'd3, Z8, Z);
    row("wd_idle",   4'b0000, Z, Z, Z3, Z8, Z, Z, 7'b0000_000, Z32, Z, Z, Z3, Z8, Z);
    // reset during DBUSY, then stray memory completions while idle
    row("r_grant",   4'b0010, Z, 64'h400, 3'd2, 8'h0F, 64'hCAFE, Z, 7'b0000_000, Z32, Z, Z, Z3, Z8, Z);
    row("r_busy",    4'b0010, Z, 64'h400, 3'd2, 8'h0F, 64'hCAFE, Z, 7'b0000_111, Z32, Z, 64'h400, 3'd2, 8'h0F, 64'hCAFE);
    row("r_reset",   4'b1010, Z, 64'h400, 3'd2, 8'h0F, 64'hCAFE, Z, 7'b0000_111, Z32, Z, 64'h400, 3'd2, 8'h0F, 64'hCAFE);
    row("r_stray1",  4'b0001, Z, Z, Z3, Z8, Z, 64'hFFFF_FFFF_FFFF_FFFF, 7'b0000_010, Z32, Z, Z, Z3, Z8, Z);
    row("r_stray2",  4'b0001, Z, Z, Z3, Z8, Z, 64'hFFFF_FFFF_FFFF_FFFF, 7'b0000_010, Z32, Z, Z, Z3, Z8, Z);
    // back-to-back fetches with single-cycle memory, word select alternating
    row("b_g0",      4'b0100, 64'h1000, Z, Z3, Z8, Z, Z, 7'b0000_000, Z32, Z, Z, Z3, Z8, Z);
    row("b_c0",      4'b0101, 64'h1000, Z, Z3, Z8, Z, 64'hAAAA_AAAA_5555_5555, 7'b1100_110, 32'h5555_5555, Z, 64'h1000, 3'd2, Z8, Z);
    row("b_g1",      4'b0101, 64'h1004, Z, Z3, Z8, Z, 64'hAAAA_AAAA_5555_5555, 7'b0000_000, Z32, Z, Z, Z3, Z8, Z);
    row("b_c1",      4'b0101, 64'h1004, Z, Z3, Z8, Z, 64'hAAAA_AAAA_5555_5555, 7'b1100_110, 32'hAAAA_AAAA, Z, 64'h1004, 3'd2, Z8, Z);
    row("b_g2",      4'b0101, 64'h1008, Z, Z3, Z8, Z, 64'h0BAD_F00D_600D_CAFE, 7'b0000_000, Z32, Z, Z, Z3, Z8, Z);
    row("b_c2",      4'b0101, 64'h1008, Z, Z3, Z8, Z, 64'h0BAD_F00D_600D_CAFE, 7'b1100_110, 32'h600D_CAFE, Z, 64'h1008, 3'd2, Z8, Z);
    row("b_idle",    4'b0000, Z, Z, Z3, Z8, Z, Z, 7'b0000_000, Z32, Z, Z, Z3, Z8, Z);

    reset = 1'b1; ireq_valid = 1'b0; ireq_addr = Z; dreq_valid = 1'b0; dreq_addr = Z;
    dreq_size = Z3; dreq_strobe = Z8; dreq_data = Z; mresp_ready = 1'b0; mresp_data = Z;
    repeat (2) @(posedge clk);
    #1;

    $display("[TB] applying %0d table vectors", vecs.size());
    foreach (vecs[i]) begin
      applyStimulus(vecs[i]);
      #4;
      checkOutput(vecs[i]);
      @(posedge clk);
      #1;
    end

    // Hand sequence: bounded wait for the memory request after a lone fetch.
    ireq_valid = 1'b1;
    ireq_addr  = 64'h2004;
    waited = 0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk);
      #1;
      waited++;
      if (mreq_valid) break;
    end
    cmp("hs_latency", 64'(waited), 64'd1);
    cmp("hs_maddr", mreq_addr, 64'h2004);
    mresp_ready = 1'b1;
    mresp_data  = 64'h7777_6666_0000_0000;
    #4;
    cmp("hs_dok", {63'h0, iresp_data_ok}, 64'd1);
    cmp("hs_idata", {32'h0, iresp_data}, {32'h0, 32'h7777_6666});
    cmp("hs_d_quiet", {63'h0, dresp_data_ok}, 64'd0);
    @(posedge clk);
    #1;
    ireq_valid  = 1'b0;
    mresp_ready = 1'b0;
    #4;
    cmp("hs_released", {63'h0, mreq_valid}, 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/core_bus_arbiter.md
Name: core_bus_arbiter

Overview:
- Sits directly downstream of the CPU core and merges its instruction-fetch port (ireq/iresp) and data port (dreq/dresp) onto one single-beat memory port.
- Arbitrates between the two ports and latches the granted request.
- Drives the request to memory until completion, then returns a one-cycle addr_ok/data_ok pulse to the winning port.
- Instruction words are extracted from the 64-bit memory beat using the fetch address.

Parameters:
- DPRIO, 1: when 1, dbus wins simultaneous requests unless the previous grant was dbus and ibus is waiting. When 0, ibus wins unless the previous grant was ibus and dbus is waiting.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- ireq_valid  in  1  core fetch request
- ireq_addr  in  64  fetch address, 4-byte aligned
- iresp_addr_ok  out  1  fetch accepted (pulse)
- iresp_data_ok  out  1  fetch data valid (pulse)
- iresp_data  out  32  fetched instruction
- dreq_valid  in  1  core data request
- dreq_addr  in  64  data address
- dreq_size  in  3  log2 of access bytes (0..3)
- dreq_strobe  in  8  byte write enables; all-zero means read
- dreq_data  in  64  write data, lane-aligned
- dresp_addr_ok  out  1  data request accepted (pulse)
- dresp_data_ok  out  1  data response valid (pulse)
- dresp_data  out  64  read data, raw 64-bit beat
- mreq_valid  out  1  memory request
- mreq_write  out  1  1 = write (strobe nonzero)
- mreq_addr  out  64  latched address
- mreq_size  out  3  latched size; fetch always 3'd2
- mreq_strobe  out  8  latched strobe; fetch 8'h00
- mreq_wdata  out  64  latched write data
- mresp_ready  in  1  memory completes current request this cycle
- mresp_data  in  64  read data, valid when mresp_ready

Behaviour:
- States: IDLE, IBUSY, DBUSY. Register last_grant (0 = ibus, 1 = dbus).
- On reset (clk edge with reset=1):
  - state=IDLE, last_grant=0.
  - All m* outputs and response outputs are 0; latched request registers are 0.
  - An outstanding memory transaction is abandoned. Memory shares the same reset, so no late mresp_ready is expected; any mresp_ready while IDLE is ignored.
- IDLE:
  - No valid request: stay IDLE.
  - Only ireq_valid: latch ireq_addr, go to IBUSY.
  - Only dreq_valid: latch addr/size/strobe/data, go to DBUSY.
  - Both valid: winner per DPRIO and last_grant rule. The loser is not latched and stays pending.
  - last_grant is updated at grant.
- Grant-to-memory latency: mreq_valid rises the cycle after the grant edge and is registered from the latch. It stays high, with all m* fields stable, until the cycle mresp_ready=1.
- IBUSY/DBUSY, cycle with mresp_ready=1:
  - Combinationally assert the granted port's addr_ok and data_ok together, for one cycle.
  - iresp_data = mresp_addr-latched bit2 ? mresp_data[63:32] : mresp_data[31:0].
  - dresp_data = mresp_data unmodified.
  - Next state IDLE; mreq_valid=0 on the next cycle.
  - Minimum spacing between two grants: one IDLE cycle.
- Response suppression: if the granted port's valid is 0 in the completion cycle (core withdrew), the transaction still completes and no addr_ok/data_ok is issued.
- Response outputs are 0 in every cycle except a completion cycle. The non-granted port never sees ok pulses.
- mreq_write = |strobe. A dbus read (strobe=0) has mreq_write=0.
- No request is accepted while busy. Inputs changing while busy do not alter m* fields.

Test Plan:
- Fetch only: ireq_valid=1, addr=0x8000_0004; memory returns mresp_data=0x1111_2222_3333_4444 after 3 cycles -> mreq_valid 3 cycles with size=2, strobe=0; one-cycle iresp_data_ok with iresp_data=0x1111_2222.
- Simultaneous requests, DPRIO=1, last_grant=0: ireq 0x8000_0000 and dreq read 0x8000_1000 -> dbus served first, then ibus granted after one IDLE cycle. If both remain valid, the alternation continues: dbus, ibus, dbus.
- dbus write: addr=0x100, size=0, strobe=8'h04, data=0x0000_0000_00AB_0000 -> mreq_write=1, fields stable across a 5-cycle stall; dresp_data_ok pulses once; iresp outputs stay 0.
- Withdrawn request: ireq_valid drops after grant, memory completes -> no iresp_data_ok pulse; state returns to IDLE; next dreq is granted normally.
- Reset mid-transaction: reset=1 during DBUSY -> next cycle mreq_valid=0, state IDLE. A stray mresp_ready while IDLE produces no ok pulses.
- Back-to-back fetches, 1-cycle memory: ireq held high with new addresses -> a grant every other cycle; bit2 word select alternates correctly for 0x...0 and 0x...4.
